// File: rtl/accum_tile_serializer_if.sv
// Tile-in / beat-out bus of the accumulator tile serializer.
// slave is the serializer side, master is the producer/consumer side.
interface accum_tile_serializer_if;
  logic [0:15][0:15][31:0] in;
  logic                    in_valid;
  logic                    in_ready;
  logic [0:15][31:0]       out_row;
  logic [3:0]              out_idx;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic                    overflow;

  modport slave  (input  in, in_valid, out_ready,
                  output in_ready, out_row, out_idx, out_valid, out_last, overflow);
  modport master (output in, in_valid, out_ready,
                  input  in_ready, out_row, out_idx, out_valid, out_last, overflow);
endinterface

// File: rtl/accum_tile_serializer.sv
// Ping-pong buffered 16x16 complex tile capture, drained one row (or column,
// when TRANSPOSE=1) of 16 complex values per valid/ready beat.
module accum_tile_serializer #(
  parameter bit TRANSPOSE = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  accum_tile_serializer_if.slave bus
);
  localparam int NUM_LANES = 16;

  typedef logic [0:NUM_LANES-1][0:NUM_LANES-1][31:0] tile_t;

  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [3:0] beat_q, beat_d;
  logic       overflow_q, overflow_d;
  tile_t      tbuf_q [2];
  tile_t      tbuf_d [2];

  logic cap, xfer, pop, valid;

  assign valid = (count_q != 2'd0);

  always_comb begin
    cap        = bus.in_valid && (count_q != 2'd2);
    xfer       = valid && bus.out_ready;
    pop        = xfer && (beat_q == 4'hf);
    tbuf_d     = tbuf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_d     = beat_q;
    overflow_d = overflow_q;
    count_d    = count_q;
    if (cap) begin
      tbuf_d[wr_ptr_q] = bus.in;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (bus.in_valid && (count_q == 2'd2)) overflow_d = 1'b1;
    if (xfer) beat_d = beat_q + 4'd1;
    if (pop) rd_ptr_d = ~rd_ptr_q;
    // A capture and a last-beat pop in the same cycle cancel out.
    case ({cap, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      beat_q     <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
    end
  end

  // Tile storage carries no reset; out_row zero-gating hides stale contents.
  always_ff @(posedge clk) begin
    tbuf_q <= tbuf_d;
  end

  for (genvar m = 0; m < NUM_LANES; m++) begin : g_lane
    logic [31:0] lane;
    if (TRANSPOSE) begin : g_col
      assign lane = tbuf_q[rd_ptr_q][m][beat_q];
    end else begin : g_row
      assign lane = tbuf_q[rd_ptr_q][beat_q][m];
    end
    assign bus.out_row[m] = valid ? lane : 32'd0;
  end

  assign bus.out_valid = valid;
  assign bus.out_idx   = beat_q;
  assign bus.out_last  = valid && (beat_q == 4'hf);
  assign bus.in_ready  = (count_q != 2'd2);
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_accum_tile_serializer.sv
// Drives a row-order and a column-order serializer with identical stimulus and
// scoreboards every transferred beat against the tiles that were sent.
module tb_accum_tile_serializer;
  typedef logic [0:15][0:15][31:0] tile_t;
  typedef logic [0:15][31:0]       row_t;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  tile_t in_t = '0;
  logic  in_v = 1'b0;
  logic  o_rdy = 1'b0;

  accum_tile_serializer_if ifc0();
  accum_tile_serializer_if ifc1();

  assign ifc0.in = in_t;  assign ifc0.in_valid = in_v;  assign ifc0.out_ready = o_rdy;
  assign ifc1.in = in_t;  assign ifc1.in_valid = in_v;  assign ifc1.out_ready = o_rdy;

  accum_tile_serializer #(.TRANSPOSE(1'b0)) u_row (.clk(clk), .reset(reset), .bus(ifc0.slave));
  accum_tile_serializer #(.TRANSPOSE(1'b1)) u_col (.clk(clk), .reset(reset), .bus(ifc1.slave));

  always #5 clk = ~clk;

  int    vectors = 0;
  int    miscompares = 0;
  tile_t tq[$];
  int    exp_beat = 0;
  logic  mon_en = 1'b0;
  logic  prev_stall = 1'b0;
  row_t  prev_row0, prev_row1;
  logic [3:0] prev_idx;

  function automatic tile_t mk_tile(input logic [7:0] tag);
    tile_t t;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        t[i][j] = {tag, i[7:0], j[15:0]};
    return t;
  endfunction

  task automatic send_tile(input logic [7:0] tag, input bit expect_kept);
    in_t = mk_tile(tag);
    in_v = 1'b1;
    if (expect_kept) tq.push_back(mk_tile(tag));
    @(posedge clk); #1;
  endtask

  // Background scoreboard: runs at every negedge, away from the active edge.
  task automatic test_scoreboard();
    tile_t t;
    row_t  e0, e1;
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        vectors++;
        if (ifc0.out_valid !== ifc1.out_valid)
          begin miscompares++; $display("FAIL valid_match row=%b col=%b", ifc0.out_valid, ifc1.out_valid); end
        if (!ifc0.out_valid) begin
          vectors++;
          if (ifc0.out_row !== '0 || ifc1.out_row !== '0 || ifc0.out_last !== 1'b0)
            begin miscompares++; $display("FAIL idle_zero row=%h col=%h", ifc0.out_row, ifc1.out_row); end
        end
        if (prev_stall) begin
          vectors++;
          if (ifc0.out_valid !== 1'b1 || ifc0.out_idx !== prev_idx || ifc0.out_row !== prev_row0 || ifc1.out_row !== prev_row1)
            begin miscompares++; $display("FAIL stall_stable valid=%b idx=%0d want idx=%0d", ifc0.out_valid, ifc0.out_idx, prev_idx); end
        end
        prev_stall = ifc0.out_valid && !o_rdy;
        prev_row0 = ifc0.out_row;  prev_row1 = ifc1.out_row;  prev_idx = ifc0.out_idx;
        if (ifc0.out_valid && o_rdy) begin
          vectors++;
          if (tq.size() == 0) begin
            miscompares++; $display("FAIL unexpected_beat idx=%0d want none", ifc0.out_idx);
          end else begin
            t = tq[0];
            for (int m = 0; m < 16; m++) begin
              e0[m] = t[exp_beat][m];
              e1[m] = t[m][exp_beat];
            end
            if (ifc0.out_idx !== exp_beat[3:0] || ifc1.out_idx !== exp_beat[3:0])
              begin miscompares++; $display("FAIL beat_idx got=%0d want=%0d", ifc0.out_idx, exp_beat); end
            if (ifc0.out_last !== (exp_beat == 15) || ifc1.out_last !== (exp_beat == 15))
              begin miscompares++; $display("FAIL beat_last got=%b want=%b", ifc0.out_last, exp_beat == 15); end
            if (ifc0.out_row !== e0)
              begin miscompares++; $display("FAIL row_data got=%h want=%h", ifc0.out_row, e0); end
            if (ifc1.out_row !== e1)
              begin miscompares++; $display("FAIL col_data got=%h want=%h", ifc1.out_row, e1); end
            exp_beat++;
            if (exp_beat == 16) begin exp_beat = 0; void'(tq.pop_front()); end
          end
        end
      end
    end
  endtask

  task automatic wait_drained(input int budget);
    int n = 0;
    while (tq.size() != 0 && n < budget) begin @(posedge clk); #1; n++; end
    vectors++;
    if (tq.size() != 0)
      begin miscompares++; $display("FAIL drain_timeout left=%0d tiles want 0", tq.size()); end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (ifc0.out_valid !== 1'b0 || ifc0.out_row !== '0 || ifc0.out_idx !== 4'd0 ||
        ifc0.out_last !== 1'b0 || ifc0.in_ready !== 1'b1 || ifc0.overflow !== 1'b0)
      begin miscompares++; $display("FAIL reset_state v=%b idx=%0d rdy=%b ovf=%b", ifc0.out_valid, ifc0.out_idx, ifc0.in_ready, ifc0.overflow); end
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single(input logic [7:0] tag);
    o_rdy = 1'b1;
    send_tile(tag, 1'b1);
    in_v = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      vectors++;
      if (ifc0.out_valid !== 1'b1)
        begin miscompares++; $display("FAIL single_valid k=%0d got=%b want=1", k, ifc0.out_valid); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    vectors++;
    if (ifc0.out_valid !== 1'b0 || tq.size() != 0)
      begin miscompares++; $display("FAIL single_end valid=%b left=%0d want 0/0", ifc0.out_valid, tq.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    o_rdy = 1'b1;
    send_tile(8'h21, 1'b1);
    send_tile(8'h22, 1'b1);
    in_v = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      vectors++;
      if (ifc0.out_valid !== (k < 31))
        begin miscompares++; $display("FAIL b2b_valid k=%0d got=%b want=%b", k, ifc0.out_valid, k < 31); end
      vectors++;
      if (ifc0.in_ready !== (k >= 15))
        begin miscompares++; $display("FAIL b2b_in_ready k=%0d got=%b want=%b", k, ifc0.in_ready, k >= 15); end
      @(posedge clk); #1;
    end
    vectors++;
    if (ifc0.overflow !== 1'b0 || tq.size() != 0)
      begin miscompares++; $display("FAIL b2b_end ovf=%b left=%0d want 0/0", ifc0.overflow, tq.size()); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    o_rdy = 1'($urandom_range(0, 1));
    send_tile(8'h31, 1'b1);
    o_rdy = 1'($urandom_range(0, 1));
    send_tile(8'h32, 1'b1);
    in_v = 1'b0;
    while (tq.size() != 0 && n < 400) begin
      o_rdy = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (tq.size() != 0)
      begin miscompares++; $display("FAIL bp_timeout left=%0d want 0", tq.size()); end
    o_rdy = 1'b1;
  endtask

  task automatic test_overflow();
    o_rdy = 1'b0;
    send_tile(8'h41, 1'b1);
    send_tile(8'h42, 1'b1);
    send_tile(8'h43, 1'b0);
    in_v = 1'b0;
    @(negedge clk);
    vectors++;
    if (ifc0.overflow !== 1'b1 || ifc0.in_ready !== 1'b0 || ifc0.out_idx !== 4'd0)
      begin miscompares++; $display("FAIL ovf_set ovf=%b rdy=%b idx=%0d want 1/0/0", ifc0.overflow, ifc0.in_ready, ifc0.out_idx); end
    repeat (5) @(posedge clk);
    #1;
    o_rdy = 1'b1;
    wait_drained(60);
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (ifc0.overflow !== 1'b1 || ifc0.out_valid !== 1'b0)
      begin miscompares++; $display("FAIL ovf_sticky ovf=%b valid=%b want 1/0", ifc0.overflow, ifc0.out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_drain();
    int n = 0;
    o_rdy = 1'b1;
    send_tile(8'h51, 1'b1);
    send_tile(8'h52, 1'b1);
    in_v = 1'b0;
    @(negedge clk);
    while (!(ifc0.out_valid && ifc0.out_idx == 4'd7) && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (n >= 20)
      begin miscompares++; $display("FAIL mid_reach idx=%0d want 7", ifc0.out_idx); end
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (ifc0.out_valid !== 1'b0 || ifc1.out_valid !== 1'b0 || ifc0.out_row !== '0 ||
        ifc0.out_idx !== 4'd0 || ifc0.out_last !== 1'b0 || ifc0.in_ready !== 1'b1 || ifc0.overflow !== 1'b0)
      begin miscompares++; $display("FAIL mid_reset v=%b idx=%0d rdy=%b ovf=%b", ifc0.out_valid, ifc0.out_idx, ifc0.in_ready, ifc0.overflow); end
    tq.delete();
    exp_beat = 0;
    prev_stall = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (ifc0.in_ready !== 1'b1 || ifc0.out_valid !== 1'b0)
      begin miscompares++; $display("FAIL post_reset rdy=%b valid=%b want 1/0", ifc0.in_ready, ifc0.out_valid); end
    mon_en = 1'b1;
    @(posedge clk); #1;
    test_single(8'h61);
  endtask

  initial begin
    fork test_scoreboard(); join_none
    test_reset();
    test_single(8'h11);
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid_drain();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/accum_tile_serializer.md
# accum_tile_serializer

Drains 16x16 complex result tiles from the complex accumulator array and streams them out one row (or column) of 16 complex values per beat under a valid/ready handshake. Sits between the accumulator array and the inverse-FFT / write-back stage. Two-entry ping-pong tile buffer, so one tile can be captured while the previous one drains. Optional transpose feeds the column pass of a 2D IFFT.

## Interface
- TRANSPOSE, 0, 0: beat k carries row k (`tile[k][0..15]`); 1: beat k carries column k (`tile[0..15][k]`).
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- in  in  complex_fxp_t [0:15][0:15]  accumulated tile, sampled only when `in_valid` is high.
- in_valid  in  1  single-cycle tile strobe, driven by the accumulator array's `output_valid`.
- in_ready  out  1  at least one tile buffer free; registered-state decode.
- out_row  out  complex_fxp_t [0:15]  current beat data; forced to all-zero while `out_valid` is low.
- out_idx  out  4  row/column index of the current beat.
- out_valid  out  1  beat available.
- out_ready  in  1  downstream accepts the beat.
- out_last  out  1  high with the beat where `out_idx`==15.
- overflow  out  1  sticky; a tile was dropped.
- complex_fxp_t is 32 bits: real [31:16], imag [15:0], both 16-bit signed fixed point, passed through unmodified.

## Operation
- State: `count` (0..2 tiles held), `wr_ptr`, `rd_ptr` (1 bit each), `beat` (4 bits), `overflow`.
- Capture: `in_valid && count<2` writes the full tile into `buf[wr_ptr]`, toggles `wr_ptr`, increments `count`.
- Drop: `in_valid && count==2` writes nothing. Pointers and count are unchanged. `overflow` sets to 1 and stays set until reset.
- `in_ready` = (`count`<2), computed from registered `count` only. A pop in the same cycle does not free a slot for that cycle's `in_valid`.
- Drain: `out_valid` = (`count`>0).
  - Beat data: `buf[rd_ptr]` row `beat` (or column `beat` if TRANSPOSE=1).
  - `out_idx` = `beat`. `out_last` = `out_valid && beat==15`.
- Handshake: a beat transfers on `out_valid && out_ready`, which increments `beat`.
  - On the transfer with `beat`==15: `beat` wraps to 0, `rd_ptr` toggles, `count` decrements.
  - `out_valid` must not drop and `out_row` / `out_idx` must not change while `out_valid && !out_ready`.
- Simultaneous capture and last-beat pop:
  - `count` 1: `count` stays 1. The new tile goes into the other buffer and drains next with no bubble.
  - `count` 2: the tile is dropped (see Drop).
- Capture never overwrites `buf[rd_ptr]` while that buffer holds a live tile; this is guaranteed by `count`.
- Buffers are not reset. Zero-gating of `out_row` hides stale contents.
- No arithmetic and no width change: data is bit-exact from input to output.

## Timing
- Reset values: `out_valid`=0, `out_row`=0, `out_idx`=0, `out_last`=0, `in_ready`=1, `overflow`=0, `count`=0, `wr_ptr`=`rd_ptr`=0, `beat`=0.
- Reset asserted mid-drain empties the block immediately, asynchronously; outputs go to reset values. Partially drained tiles are discarded.
- Latency: `in_valid` at edge N with `count`==0 gives `out_valid`=1 with beat 0 of that tile from cycle N+1.
- Throughput: with `out_ready` held high, one beat per cycle and 16 cycles per tile. Back-to-back tiles stream with no idle cycle between beat 15 and the next beat 0.
- `in_ready` falls the cycle after the second tile is captured. It rises the cycle after the last beat of the draining tile transfers.
- All outputs are registered-state decodes (`out_row` is a buffer mux). No combinational path from `out_ready` or `in_valid` to any output.

## Test plan
- Single tile, TRANSPOSE=0: tile[i][j] = {i,j} packed into real/imag, `out_ready`=1 → 16 beats on cycles N+1..N+16, beat k = {k,0..15}. `out_last` only on k=15. `out_valid` low from N+17; `out_row`=0 while idle.
- TRANSPOSE=1, same tile → beat k element m = {m,k}.
- Two tiles 1 cycle apart with `out_ready`=1 → 32 contiguous beats, tile A then tile B. `in_ready` low from the cycle after B's capture until the cycle after A's beat 15 transfers. `overflow`=0.
- Backpressure: `out_ready` random 50% → beats arrive in order with no duplicates or losses. Data and `out_idx` stay stable whenever `out_valid && !out_ready`.
- Overflow: three tiles on consecutive cycles with `out_ready`=0 → third tile dropped, `overflow`=1 and sticky. After releasing `out_ready`, only tiles 1 and 2 are emitted.
- Reset asserted at beat 7 of a tile with a second tile queued → all outputs at reset values the same cycle. After release, `in_ready`=1, `out_valid`=0, and a fresh tile drains from beat 0.
